uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver: configurable data width, parity and stop bits.
//  Synchronises the async rx line and validates start, parity and stop bits.
//  Buffers received words plus error flags in a small FWFT FIFO, drained by valid/ready.
//  Sits between the board serial pin and the host-command decoder of the SPC700 debug path.
// PARAMETERS
//  CLOCKS_PER_BIT  8  clock cycles per serial bit; legal >= 4
//  DATA_BITS       8  data bits per frame; legal 5..9
//  PARITY_MODE     0  0 = none, 1 = odd, 2 = even
//  STOP_BITS       1  stop bits expected; legal 1 or 2
//  FIFO_DEPTH      4  receive FIFO entries; power of 2, >= 2
// PORTS
//  clock          in   1                 system clock
//  reset          in   1                 synchronous, active-high
//  rx             in   1                 async serial line, idle high
//  rx_data        out  DATA_BITS         FIFO head data, LSB = first bit received
//  rx_parity_err  out  1                 FIFO head parity mismatch flag
//  rx_frame_err   out  1                 FIFO head stop bit sampled low
//  rx_valid       out  1                 FIFO not empty
//  rx_ready       in   1                 consumer accepts head when rx_valid is high
//  overrun        out  1                 sticky: a word was dropped because the FIFO was full
//  clear_overrun  in   1                 clears overrun on the next edge
//  fifo_count     out  $clog2(DEPTH)+1   FIFO occupancy
//  busy           out  1                 frame in progress (state != IDLE)
// BEHAVIOUR
//  Reset: both synchroniser flops = 1, state IDLE, FIFO empty, rx_valid = 0, overrun = 0, busy = 0.
//   rx_data and error flags = 0. Reset mid-frame discards the partial frame.
//  Sync: 2-flop synchroniser; rx_s is the second flop. All decisions use rx_s only.
//  FSM: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. Bit counter counts 0..CLOCKS_PER_BIT-1.
//   IDLE   : rx_s == 0 -> START, counter = 0.
//   START  : at count (CLOCKS_PER_BIT-1)/2 (mid-bit), sample rx_s.
//            Sample 1 -> false start, back to IDLE. Sample 0 -> DATA, counter = 0.
//   DATA   : sample at each count CLOCKS_PER_BIT-1 (mid-bit, one bit period after the last).
//            Shift LSB-first into shreg[DATA_BITS-1:0].
//            After DATA_BITS samples -> PARITY if PARITY_MODE != 0, else STOP.
//   PARITY : sample one bit; perr = (^shreg ^ bit) != (PARITY_MODE == 1).
//            Odd: XOR of data and parity must be 1; even: must be 0.
//   STOP   : sample STOP_BITS bits; ferr = any sampled stop bit == 0.
//            At the last stop sample, push {ferr, perr, shreg} into the FIFO.
//            Then: ferr = 0 -> IDLE in the same cycle; ferr = 1 -> WAIT_IDLE.
//   WAIT_IDLE: stay until rx_s == 1 (break / line-low handling), then IDLE. No push.
//  Latency: push occurs at the mid-sample of the last stop bit; rx_valid rises the next cycle.
//  FIFO: first-word-fall-through; pop = rx_valid & rx_ready; head flags travel with data.
//   Empty: rx_valid = 0, rx_data holds its last value, pop is ignored.
//   Full with push and no pop: word dropped, overrun <= 1.
//   Full with simultaneous push and pop: both take effect, no overrun, count unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//  overrun: set wins over clear_overrun in the same cycle.
//  busy = (state != IDLE).
// STRUCTURE
//  uart_pkg: PARITY_NONE/ODD/EVEN constants, FSM state encodings, uart_rx_word_t {ferr, perr, data}.
//  Sub-module uart_rx_fifo: sync FWFT FIFO, params WIDTH and DEPTH,
//   ports push/din/full, pop/dout/empty, count.
//  Top level holds the synchroniser, bit/sample counters, FSM and shift register.
// TESTING (CLOCKS_PER_BIT = 8 unless noted)
//  1. Defaults, send 0xA5, 8N1, rx_ready = 1
//     -> one rx_valid beat, rx_data = 0xA5, both error flags 0, overrun = 0.
//  2. PARITY_MODE = 2, send 0x07 with parity bit 0 (wrong)
//     -> rx_data = 0x07, rx_parity_err = 1. Resend with parity 1 -> rx_parity_err = 0.
//  3. STOP_BITS = 2, second stop bit held low for 20 bit times
//     -> rx_frame_err = 1, busy stays 1 until rx returns high, then no further word.
//  4. rx low pulse of 3 clocks -> false start: no word, busy back to 0 within 8 clocks.
//  5. rx_ready = 0, send 5 frames with FIFO_DEPTH = 4
//     -> fifo_count = 4, overrun = 1, first 4 bytes retained in order.
//     Then clear_overrun -> overrun = 0.
//  6. Reset asserted mid-DATA
//     -> FIFO empty, busy = 0. The next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared constants, FSM encoding and word record for the UART RX
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_ODD    = 1;
  localparam int PARITY_EVEN   = 2;
  localparam int MAX_DATA_BITS = 9;
  localparam int BIT_W         = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  typedef struct packed {
    logic                     ferr;
    logic                     perr;
    logic [MAX_DATA_BITS-1:0] data;
  } uart_rx_word_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo : synchronous first-word-fall-through FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg : configurable UART receiver with FWFT receive FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  input  logic                          clear_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int               CNT_W     = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam int               WORD_W    = DATA_BITS + 2;

  logic                 sync_q1;
  logic                 rx_s;
  rx_state_t            state;
  rx_state_t            next_state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 sample;
  logic                 push;
  logic                 pop;
  logic                 last_stop;
  logic                 ferr_final;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WORD_W-1:0]    push_word;
  logic [WORD_W-1:0]    head_word;
  logic [WORD_W-1:0]    held_word;
  logic [WORD_W-1:0]    out_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync_q1 <= rx;
      rx_s    <= sync_q1;
    end
  end

  assign last_stop  = (bit_cnt == STOP_LAST);
  assign ferr_final = ferr | ~rx_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (!rx_s) next_state = ST_START;
      ST_START:     if (sample) next_state = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (sample && bit_cnt == DATA_LAST)
                      next_state = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (sample) next_state = ST_STOP;
      ST_STOP:      if (sample && last_stop)
                      next_state = ferr_final ? ST_WAIT_IDLE : ST_IDLE;
      ST_WAIT_IDLE: if (rx_s) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    sample = 1'b0;
    case (state)
      ST_START:                   sample = (clk_cnt == CNT_MID);
      ST_DATA, ST_PARITY, ST_STOP: sample = (clk_cnt == CNT_LAST);
      default:                    sample = 1'b0;
    endcase
    push = (state == ST_STOP) && sample && last_stop;
    busy = (state != ST_IDLE);
  end

  // The counter restarts at every sample, so later samples land one bit period apart.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      clk_cnt <= (state == ST_IDLE || sample) ? '0 : clk_cnt + 1'b1;
      if (next_state != state) begin
        bit_cnt <= '0;
      end else if (sample) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == ST_IDLE) begin
        perr <= 1'b0;
        ferr <= 1'b0;
      end
      if (state == ST_DATA && sample) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      end
      if (state == ST_PARITY && sample) begin
        perr <= (((^shreg) ^ rx_s) != (PARITY_MODE == PARITY_ODD));
      end
      if (state == ST_STOP && sample && !rx_s) begin
        ferr <= 1'b1;
      end
    end
  end

  assign push_word = {ferr_final, perr, shreg};
  assign pop       = rx_valid & rx_ready;
  assign rx_valid  = ~fifo_empty;

  uart_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (push_word),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (head_word),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Keeps the last delivered word visible while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      held_word <= '0;
    end else if (pop) begin
      held_word <= head_word;
    end
  end

  assign out_word      = rx_valid ? head_word : held_word;
  assign rx_data       = out_word[DATA_BITS-1:0];
  assign rx_parity_err = out_word[DATA_BITS];
  assign rx_frame_err  = out_word[DATA_BITS+1];

  always_ff @(posedge clock) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg : directed and randomized frames against three receiver configs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_cfg;

  localparam int NBITS [3] = '{8, 8, 7};
  localparam int PAR   [3] = '{0, 2, 1};
  localparam int NSTOP [3] = '{1, 2, 1};
  localparam int CPB   [3] = '{8, 8, 5};
  localparam int DEPTH [3] = '{4, 4, 2};

  logic clock;
  logic reset;
  logic rx_in [3];
  logic rdy   [3];
  logic clr   [3];

  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic [2:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic perr_a, perr_b, perr_c, ferr_a, ferr_b, ferr_c;
  logic val_a, val_b, val_c, ovr_a, ovr_b, ovr_c, busy_a, busy_b, busy_c;

  logic [8:0] o_data [3];
  logic [2:0] o_cnt  [3];
  logic       o_perr [3];
  logic       o_ferr [3];
  logic       o_val  [3];
  logic       o_ovr  [3];
  logic       o_busy [3];

  logic [10:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  uart_rx_cfg #(.CLOCKS_PER_BIT(8), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clock(clock), .reset(reset), .rx(rx_in[0]), .rx_data(data_a), .rx_parity_err(perr_a),
    .rx_frame_err(ferr_a), .rx_valid(val_a), .rx_ready(rdy[0]), .overrun(ovr_a),
    .clear_overrun(clr[0]), .fifo_count(cnt_a), .busy(busy_a));

  uart_rx_cfg #(.CLOCKS_PER_BIT(8), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clock(clock), .reset(reset), .rx(rx_in[1]), .rx_data(data_b), .rx_parity_err(perr_b),
    .rx_frame_err(ferr_b), .rx_valid(val_b), .rx_ready(rdy[1]), .overrun(ovr_b),
    .clear_overrun(clr[1]), .fifo_count(cnt_b), .busy(busy_b));

  uart_rx_cfg #(.CLOCKS_PER_BIT(5), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(2)) dut_c (
    .clock(clock), .reset(reset), .rx(rx_in[2]), .rx_data(data_c), .rx_parity_err(perr_c),
    .rx_frame_err(ferr_c), .rx_valid(val_c), .rx_ready(rdy[2]), .overrun(ovr_c),
    .clear_overrun(clr[2]), .fifo_count(cnt_c), .busy(busy_c));

  always_comb begin
    o_data[0] = {1'b0, data_a};  o_data[1] = {1'b0, data_b};  o_data[2] = {2'b0, data_c};
    o_cnt[0]  = cnt_a;           o_cnt[1]  = cnt_b;           o_cnt[2]  = {1'b0, cnt_c};
    o_perr[0] = perr_a;          o_perr[1] = perr_b;          o_perr[2] = perr_c;
    o_ferr[0] = ferr_a;          o_ferr[1] = ferr_b;          o_ferr[2] = ferr_c;
    o_val[0]  = val_a;           o_val[1]  = val_b;           o_val[2]  = val_c;
    o_ovr[0]  = ovr_a;           o_ovr[1]  = ovr_b;           o_ovr[2]  = ovr_c;
    o_busy[0] = busy_a;          o_busy[1] = busy_b;          o_busy[2] = busy_c;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference word: data as sent, parity judged by counting ones, any low stop bit is a frame error.
  function automatic logic [10:0] model_word(input logic [8:0] data, input int nbits, input int par_mode,
                                             input logic pbit, input int nstop, input logic [1:0] stop_lvl);
    logic [8:0] d;
    int         ones;
    logic       pe;
    logic       fe;
    d    = data & ((9'd1 << nbits) - 9'd1);
    ones = $countones(d) + int'(pbit);
    pe   = 1'b0;
    fe   = 1'b0;
    if (par_mode == 1) pe = ((ones % 2) != 1);
    if (par_mode == 2) pe = ((ones % 2) != 0);
    for (int i = 0; i < nstop; i++) if (!stop_lvl[i]) fe = 1'b1;
    return {fe, pe, d};
  endfunction

  task automatic send_frame(input int sel, input logic [8:0] data, input logic pbit, input logic [1:0] stop_lvl);
    logic [15:0] frame;
    int          len;
    frame    = '1;
    frame[0] = 1'b0;
    len      = 1;
    for (int i = 0; i < NBITS[sel]; i++) begin frame[len] = data[i]; len++; end
    if (PAR[sel] != 0) begin frame[len] = pbit; len++; end
    for (int i = 0; i < NSTOP[sel]; i++) begin frame[len] = stop_lvl[i]; len++; end
    for (int i = 0; i < len; i++) begin
      rx_in[sel] = frame[i];
      repeat (CPB[sel]) @(negedge clock);
    end
    rx_in[sel] = 1'b1;
  endtask

  task automatic rand_frame(input int sel, input bit keep);
    logic [8:0] d;
    logic       pb;
    logic [1:0] st;
    d  = 9'($urandom);
    pb = 1'($urandom);
    st = 2'b11;
    if ($urandom_range(0, 4) == 0) st[0] = 1'b0;
    if ($urandom_range(0, 4) == 0) st[1] = 1'b0;
    send_frame(sel, d, pb, st);
    if (keep) exp_q.push_back(model_word(d, NBITS[sel], PAR[sel], pb, NSTOP[sel], st));
    repeat (2 * CPB[sel]) @(negedge clock);
  endtask

  task automatic wait_valid(input int sel, input int budget);
    int n;
    n = 0;
    while (!o_val[sel] && n < budget) begin @(negedge clock); n++; end
    if (!o_val[sel]) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int sel);
    logic [10:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("head_valid", 32'(o_val[sel]), 32'd1);
      check("head_data",  32'(o_data[sel]), 32'(e[8:0]));
      check("head_perr",  32'(o_perr[sel]), 32'(e[9]));
      check("head_ferr",  32'(o_ferr[sel]), 32'(e[10]));
      rdy[sel] = 1'b1;
      @(negedge clock);
      rdy[sel] = 1'b0;
    end
    check("drained_empty", 32'(o_val[sel]), 32'd0);
  endtask

  task automatic random_batch(input int sel);
    int n;
    n = int'($urandom_range(1, DEPTH[sel]));
    for (int k = 0; k < n; k++) rand_frame(sel, 1'b1);
    check("batch_count", 32'(o_cnt[sel]), 32'(n));
    check("batch_no_overrun", 32'(o_ovr[sel]), 32'd0);
    drain(sel);
  endtask

  task automatic overrun_test(input int sel);
    for (int k = 0; k <= DEPTH[sel]; k++) rand_frame(sel, k < DEPTH[sel]);
    check("ovr_count", 32'(o_cnt[sel]), 32'(DEPTH[sel]));
    check("ovr_set", 32'(o_ovr[sel]), 32'd1);
    drain(sel);
    check("ovr_sticky", 32'(o_ovr[sel]), 32'd1);
    clr[sel] = 1'b1;
    @(negedge clock);
    clr[sel] = 1'b0;
    check("ovr_cleared", 32'(o_ovr[sel]), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    for (int s = 0; s < 3; s++) begin rx_in[s] = 1'b1; rdy[s] = 1'b0; clr[s] = 1'b0; end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("rst_valid", 32'(o_val[s]), 32'd0);
      check("rst_busy",  32'(o_busy[s]), 32'd0);
      check("rst_ovr",   32'(o_ovr[s]), 32'd0);
      check("rst_count", 32'(o_cnt[s]), 32'd0);
      check("rst_data",  32'(o_data[s]), 32'd0);
      check("rst_perr",  32'(o_perr[s]), 32'd0);
      check("rst_ferr",  32'(o_ferr[s]), 32'd0);
    end
    repeat (4) @(negedge clock);

    // Single 0xA5 with the consumer always ready: one valid beat.
    rdy[0] = 1'b1;
    fork
      send_frame(0, 9'h0A5, 1'b0, 2'b11);
      begin
        wait_valid(0, 200);
        check("a5_data", 32'(o_data[0]), 32'h0A5);
        check("a5_perr", 32'(o_perr[0]), 32'd0);
        check("a5_ferr", 32'(o_ferr[0]), 32'd0);
        check("a5_ovr",  32'(o_ovr[0]), 32'd0);
        @(negedge clock);
        check("a5_one_beat", 32'(o_val[0]), 32'd0);
        check("a5_count", 32'(o_cnt[0]), 32'd0);
        check("a5_held", 32'(o_data[0]), 32'h0A5);
      end
    join
    rdy[0] = 1'b0;
    repeat (16) @(negedge clock);

    for (int b = 0; b < 3; b++) random_batch(0);
    overrun_test(0);

    // False start: line low for 3 clocks only.
    rx_in[0] = 1'b0;
    repeat (3) @(negedge clock);
    rx_in[0] = 1'b1;
    check("fs_busy_seen", 32'(o_busy[0]), 32'd1);
    repeat (8) @(negedge clock);
    check("fs_busy_clear", 32'(o_busy[0]), 32'd0);
    check("fs_no_word", 32'(o_val[0]), 32'd0);

    // Reset in the middle of the data bits.
    rand_frame(0, 1'b0);
    check("pre_rst_count", 32'(o_cnt[0]), 32'd1);
    rx_in[0] = 1'b0; repeat (8) @(negedge clock);
    rx_in[0] = 1'b0; repeat (8) @(negedge clock);
    rx_in[0] = 1'b0; repeat (8) @(negedge clock);
    rx_in[0] = 1'b1; repeat (4) @(negedge clock);
    check("mid_busy", 32'(o_busy[0]), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_busy", 32'(o_busy[0]), 32'd0);
    check("mid_rst_valid", 32'(o_val[0]), 32'd0);
    check("mid_rst_count", 32'(o_cnt[0]), 32'd0);
    repeat (8) @(negedge clock);
    send_frame(0, 9'h03C, 1'b0, 2'b11);
    exp_q.push_back(model_word(9'h03C, 8, 0, 1'b0, 1, 2'b11));
    repeat (16) @(negedge clock);
    drain(0);

    // Even parity, 2 stop bits: 0x07 with a wrong then a right parity bit.
    send_frame(1, 9'h007, 1'b0, 2'b11);
    repeat (16) @(negedge clock);
    check("par_wrong_data", 32'(o_data[1]), 32'h007);
    check("par_wrong_flag", 32'(o_perr[1]), 32'd1);
    rdy[1] = 1'b1; @(negedge clock); rdy[1] = 1'b0;
    send_frame(1, 9'h007, 1'b1, 2'b11);
    repeat (16) @(negedge clock);
    check("par_right_data", 32'(o_data[1]), 32'h007);
    check("par_right_flag", 32'(o_perr[1]), 32'd0);
    rdy[1] = 1'b1; @(negedge clock); rdy[1] = 1'b0;
    for (int b = 0; b < 3; b++) random_batch(1);

    // Second stop bit held low for 20 bit times.
    begin
      logic [8:0] d;
      logic       pb;
      d  = 9'($urandom);
      pb = 1'($urandom);
      send_frame(1, d, pb, 2'b01);
      rx_in[1] = 1'b0;
      repeat (20 * 8 - 8) @(negedge clock);
      exp_q.push_back(model_word(d, 8, 2, pb, 2, 2'b01));
      check("brk_count", 32'(o_cnt[1]), 32'd1);
      check("brk_ferr", 32'(o_ferr[1]), 32'd1);
      check("brk_busy", 32'(o_busy[1]), 32'd1);
      rx_in[1] = 1'b1;
      repeat (8) @(negedge clock);
      check("brk_idle", 32'(o_busy[1]), 32'd0);
      check("brk_no_extra", 32'(o_cnt[1]), 32'd1);
      drain(1);
    end

    // Odd parity, 7 data bits, 5 clocks per bit, depth 2.
    for (int b = 0; b < 4; b++) random_batch(2);
    overrun_test(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
